// File: rtl/rename_unit_nw.sv
// N-wide register rename: speculative RAT, committed RAT and free list.
// Renames one group per accepted cycle, frees at commit, restores on flush.
module rename_unit_nw #(
   parameter int WIDTH        = 2,
   parameter int ARCH_REGS    = 32,
   parameter int PHYS_REGS    = 64,
   parameter int RETIRE_WIDTH = 2,
   localparam int AW = $clog2(ARCH_REGS),
   localparam int PW = $clog2(PHYS_REGS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH*AW-1:0]        in_rs1,
   input  logic [WIDTH*AW-1:0]        in_rs2,
   input  logic [WIDTH*AW-1:0]        in_rd,
   input  logic [WIDTH-1:0]           in_rd_we,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH*PW-1:0]        out_p_rs1,
   output logic [WIDTH*PW-1:0]        out_p_rs2,
   output logic [WIDTH*PW-1:0]        out_p_rd,
   output logic [WIDTH*PW-1:0]        out_p_old_rd,
   input  logic [RETIRE_WIDTH-1:0]    commit_valid,
   input  logic [RETIRE_WIDTH*AW-1:0] commit_rd,
   input  logic [RETIRE_WIDTH*PW-1:0] commit_p_rd,
   input  logic [RETIRE_WIDTH*PW-1:0] commit_p_old_rd,
   input  logic                       flush,
   output logic [PW:0]                free_count
);

   logic [PW-1:0]        r_spec_rat [ARCH_REGS];
   logic [PW-1:0]        r_com_rat  [ARCH_REGS];
   logic [PHYS_REGS-1:0] r_free;
   logic [PW:0]          r_free_count;
   logic                 r_out_valid;
   logic [WIDTH*PW-1:0]  r_p_rs1;
   logic [WIDTH*PW-1:0]  r_p_rs2;
   logic [WIDTH*PW-1:0]  r_p_rd;
   logic [WIDTH*PW-1:0]  r_p_old_rd;

   logic [WIDTH-1:0]     w_alloc;
   logic [PW:0]          w_need;
   logic                 w_fire;
   logic [WIDTH*PW-1:0]  w_p_rs1;
   logic [WIDTH*PW-1:0]  w_p_rs2;
   logic [WIDTH*PW-1:0]  w_p_rd;
   logic [WIDTH*PW-1:0]  w_p_old_rd;
   logic [PHYS_REGS-1:0] w_alloc_mask;
   logic [PW-1:0]        w_com_rat_nx  [ARCH_REGS];
   logic [PW-1:0]        w_spec_rat_nx [ARCH_REGS];
   logic [PHYS_REGS-1:0] w_free_commit;
   logic [PHYS_REGS-1:0] w_free_flush;
   logic [PHYS_REGS-1:0] w_free_nx;
   logic [PW:0]          w_free_cnt_nx;

   // Lanes take the lowest free regs in lane order, from pre-commit state.
   always_comb begin
      logic [PHYS_REGS-1:0] v_avail;
      logic [PW-1:0]        v_idx;
      logic                 v_found;
      w_need  = '0;
      w_p_rd  = '0;
      w_alloc = '0;
      v_avail = r_free;
      for (int i = 0; i < WIDTH; i++) begin
         w_alloc[i] = in_rd_we[i] && (in_rd[i*AW +: AW] != '0);
         w_need     = w_need + (PW+1)'(w_alloc[i]);
         v_found    = 1'b0;
         v_idx      = '0;
         if (w_alloc[i]) begin
            for (int p = 1; p < PHYS_REGS; p++) begin
               if (!v_found && v_avail[p]) begin
                  v_found = 1'b1;
                  v_idx   = PW'(p);
               end
            end
            if (v_found) v_avail[v_idx] = 1'b0;
            w_p_rd[i*PW +: PW] = v_idx;
         end
      end
      w_alloc_mask = r_free & ~v_avail;
   end

   always_comb begin
      w_p_rs1    = '0;
      w_p_rs2    = '0;
      w_p_old_rd = '0;
      for (int j = 0; j < WIDTH; j++) begin
         w_p_rs1[j*PW +: PW]    = r_spec_rat[in_rs1[j*AW +: AW]];
         w_p_rs2[j*PW +: PW]    = r_spec_rat[in_rs2[j*AW +: AW]];
         w_p_old_rd[j*PW +: PW] = r_spec_rat[in_rd[j*AW +: AW]];
         for (int i = 0; i < j; i++) begin
            if (w_alloc[i]) begin
               if (in_rd[i*AW +: AW] == in_rs1[j*AW +: AW])
                  w_p_rs1[j*PW +: PW] = w_p_rd[i*PW +: PW];
               if (in_rd[i*AW +: AW] == in_rs2[j*AW +: AW])
                  w_p_rs2[j*PW +: PW] = w_p_rd[i*PW +: PW];
               if (in_rd[i*AW +: AW] == in_rd[j*AW +: AW])
                  w_p_old_rd[j*PW +: PW] = w_p_rd[i*PW +: PW];
            end
         end
         if (!w_alloc[j]) w_p_old_rd[j*PW +: PW] = '0;
      end
   end

   assign in_ready = !flush && (!r_out_valid || out_ready) &&
                     (r_free_count >= w_need);
   assign w_fire   = in_valid && in_ready;

   always_comb begin
      w_free_commit = r_free;
      for (int a = 0; a < ARCH_REGS; a++) w_com_rat_nx[a] = r_com_rat[a];
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
         if (commit_valid[k]) begin
            if (commit_rd[k*AW +: AW] != '0)
               w_com_rat_nx[commit_rd[k*AW +: AW]] = commit_p_rd[k*PW +: PW];
            if (commit_p_old_rd[k*PW +: PW] != '0)
               w_free_commit[commit_p_old_rd[k*PW +: PW]] = 1'b1;
         end
      end
   end

   // Recovery: everything not held by the committed map is free.
   always_comb begin
      w_free_flush = '1;
      for (int a = 0; a < ARCH_REGS; a++) w_free_flush[w_com_rat_nx[a]] = 1'b0;
   end

   always_comb begin
      for (int a = 0; a < ARCH_REGS; a++)
         w_spec_rat_nx[a] = flush ? w_com_rat_nx[a] : r_spec_rat[a];
      w_free_nx = flush ? w_free_flush : w_free_commit;
      if (w_fire) begin
         w_free_nx = w_free_commit & ~w_alloc_mask;
         for (int i = 0; i < WIDTH; i++)
            if (w_alloc[i]) w_spec_rat_nx[in_rd[i*AW +: AW]] = w_p_rd[i*PW +: PW];
      end
      w_free_cnt_nx = '0;
      for (int p = 0; p < PHYS_REGS; p++)
         w_free_cnt_nx = w_free_cnt_nx + (PW+1)'(w_free_nx[p]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int a = 0; a < ARCH_REGS; a++) begin
            r_spec_rat[a] <= PW'(a);
            r_com_rat[a]  <= PW'(a);
         end
         r_free       <= {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
         r_free_count <= (PW+1)'(PHYS_REGS-ARCH_REGS);
         r_out_valid  <= 1'b0;
         r_p_rs1      <= '0;
         r_p_rs2      <= '0;
         r_p_rd       <= '0;
         r_p_old_rd   <= '0;
      end else begin
         r_spec_rat   <= w_spec_rat_nx;
         r_com_rat    <= w_com_rat_nx;
         r_free       <= w_free_nx;
         r_free_count <= w_free_cnt_nx;
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_p_rs1     <= w_p_rs1;
            r_p_rs2     <= w_p_rs2;
            r_p_rd      <= w_p_rd;
            r_p_old_rd  <= w_p_old_rd;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_p_rs1    = r_p_rs1;
   assign out_p_rs2    = r_p_rs2;
   assign out_p_rd     = r_p_rd;
   assign out_p_old_rd = r_p_old_rd;
   assign free_count   = r_free_count;

   for (genvar k = 0; k < RETIRE_WIDTH; k++) begin : g_free_chk
      a_no_double_free: assert property (@(posedge clk) disable iff (reset)
         (commit_valid[k] && commit_p_old_rd[k*PW +: PW] != '0)
         |-> !r_free[commit_p_old_rd[k*PW +: PW]]);
   end

endmodule

// File: tb/tb_rename_unit_nw.sv
// Bench for rename_unit_nw: sequential-lane reference model plus
// directed scenarios and randomized traffic with in-order commits.
module tb_rename_unit_nw;
   localparam int WIDTH = 2;
   localparam int AW    = 5;
   localparam int PW    = 6;
   localparam int RW    = 2;
   localparam int NA    = 32;
   localparam int NP    = 64;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                in_valid, in_ready;
   logic [WIDTH*AW-1:0] in_rs1, in_rs2, in_rd;
   logic [WIDTH-1:0]    in_rd_we;
   logic                out_valid, out_ready;
   logic [WIDTH*PW-1:0] out_p_rs1, out_p_rs2, out_p_rd, out_p_old_rd;
   logic [RW-1:0]       commit_valid;
   logic [RW*AW-1:0]    commit_rd;
   logic [RW*PW-1:0]    commit_p_rd, commit_p_old_rd;
   logic                flush;
   logic [PW:0]         free_count;

   always #5 clk = ~clk;

   rename_unit_nw #(.WIDTH(WIDTH), .ARCH_REGS(NA), .PHYS_REGS(NP),
                    .RETIRE_WIDTH(RW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_p_rs1(out_p_rs1), .out_p_rs2(out_p_rs2),
      .out_p_rd(out_p_rd), .out_p_old_rd(out_p_old_rd),
      .commit_valid(commit_valid), .commit_rd(commit_rd),
      .commit_p_rd(commit_p_rd), .commit_p_old_rd(commit_p_old_rd),
      .flush(flush), .free_count(free_count));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(string nm, longint unsigned act, longint unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Reference model: lanes renamed one after another against a map.
   int m_srat [NA];
   int m_crat [NA];
   bit m_free [NP];
   bit m_oval;
   int m_o_rs1 [WIDTH];
   int m_o_rs2 [WIDTH];
   int m_o_rd  [WIDTH];
   int m_o_old [WIDTH];
   typedef struct { int rd; int prd; int pold; } ent_t;
   ent_t q [$];

   function automatic int lane(logic [WIDTH*AW-1:0] v, int i);
      return int'(v[i*AW +: AW]);
   endfunction

   function automatic int m_nfree();
      int c = 0;
      for (int p = 0; p < NP; p++) if (m_free[p]) c++;
      return c;
   endfunction

   function automatic bit m_ready();
      int need = 0;
      for (int i = 0; i < WIDTH; i++)
         if (in_rd_we[i] && lane(in_rd, i) != 0) need++;
      return !flush && (!m_oval || out_ready) && (m_nfree() >= need);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int a = 0; a < NA; a++) begin
            m_srat[a] = a;
            m_crat[a] = a;
         end
         for (int p = 0; p < NP; p++) m_free[p] = (p >= NA);
         m_oval = 1'b0;
         q.delete();
      end else begin : upd
         bit rdy;
         int r, p, cr, cold;
         rdy = m_ready();
         for (int k = 0; k < RW; k++)
            if (commit_valid[k] && q.size() > 0) void'(q.pop_front());
         if (!flush && in_valid && rdy) begin
            for (int i = 0; i < WIDTH; i++) begin
               m_o_rs1[i] = m_srat[lane(in_rs1, i)];
               m_o_rs2[i] = m_srat[lane(in_rs2, i)];
               r = lane(in_rd, i);
               if (in_rd_we[i] && r != 0) begin
                  p = 0;
                  for (int x = NP-1; x >= 1; x--) if (m_free[x]) p = x;
                  m_o_old[i] = m_srat[r];
                  m_o_rd[i]  = p;
                  m_free[p]  = 1'b0;
                  m_srat[r]  = p;
                  q.push_back('{r, p, m_o_old[i]});
               end else begin
                  m_o_old[i] = 0;
                  m_o_rd[i]  = 0;
               end
            end
            m_oval = 1'b1;
         end else if (out_ready) begin
            m_oval = 1'b0;
         end
         for (int k = 0; k < RW; k++) begin
            if (commit_valid[k]) begin
               cr   = int'(commit_rd[k*AW +: AW]);
               cold = int'(commit_p_old_rd[k*PW +: PW]);
               if (cr != 0) m_crat[cr] = int'(commit_p_rd[k*PW +: PW]);
               if (cold != 0) m_free[cold] = 1'b1;
            end
         end
         if (flush) begin
            for (int a = 0; a < NA; a++) m_srat[a] = m_crat[a];
            for (int x = 0; x < NP; x++) m_free[x] = 1'b1;
            for (int a = 0; a < NA; a++) m_free[m_crat[a]] = 1'b0;
            m_oval = 1'b0;
            q.delete();
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("cmp_in_ready", in_ready, m_ready());
         chk("cmp_out_valid", out_valid, m_oval);
         chk("cmp_free_count", free_count, m_nfree());
         if (m_oval) begin
            for (int i = 0; i < WIDTH; i++) begin
               chk($sformatf("cmp_p_rs1[%0d]", i), out_p_rs1[i*PW +: PW], m_o_rs1[i]);
               chk($sformatf("cmp_p_rs2[%0d]", i), out_p_rs2[i*PW +: PW], m_o_rs2[i]);
               chk($sformatf("cmp_p_rd[%0d]", i), out_p_rd[i*PW +: PW], m_o_rd[i]);
               chk($sformatf("cmp_p_old[%0d]", i), out_p_old_rd[i*PW +: PW], m_o_old[i]);
            end
         end
      end
   end

   function automatic int o_rs1(int i); return int'(out_p_rs1[i*PW +: PW]); endfunction
   function automatic int o_rs2(int i); return int'(out_p_rs2[i*PW +: PW]); endfunction
   function automatic int o_rd(int i);  return int'(out_p_rd[i*PW +: PW]); endfunction
   function automatic int o_old(int i); return int'(out_p_old_rd[i*PW +: PW]); endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = '0;
      out_ready = 1; commit_valid = '0; commit_rd = '0;
      commit_p_rd = '0; commit_p_old_rd = '0; flush = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      idle();
      tick();
      tick();
      reset = 0;
   endtask

   task automatic set_lane(int i, int rs1, int rs2, int rd, bit we);
      in_rs1[i*AW +: AW] = AW'(rs1);
      in_rs2[i*AW +: AW] = AW'(rs2);
      in_rd[i*AW +: AW]  = AW'(rd);
      in_rd_we[i]        = we;
      in_valid           = 1;
   endtask

   task automatic set_commit(int k, int rd, int prd, int pold);
      commit_valid[k]             = 1'b1;
      commit_rd[k*AW +: AW]       = AW'(rd);
      commit_p_rd[k*PW +: PW]     = PW'(prd);
      commit_p_old_rd[k*PW +: PW] = PW'(pold);
   endtask

   task automatic drive_random();
      bit prev;
      idle();
      in_valid = ($urandom % 4) != 0;
      for (int i = 0; i < WIDTH; i++) begin
         in_rs1[i*AW +: AW] = AW'($urandom % 8);
         in_rs2[i*AW +: AW] = AW'($urandom % 8);
         in_rd[i*AW +: AW]  = AW'($urandom % 8);
         in_rd_we[i]        = ($urandom % 4) != 0;
      end
      out_ready = ($urandom % 4) != 0;
      prev = 1'b1;
      for (int k = 0; k < RW; k++) begin
         if (prev && k < q.size() && ($urandom % 2) == 1)
            set_commit(k, q[k].rd, q[k].prd, q[k].pold);
         else
            prev = 1'b0;
      end
      flush = ($urandom % 50) == 0;
   endtask

   initial begin
      idle();
      reset = 1;
      tick();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_free_count", free_count, 32);
      chk("rst_p_rd", out_p_rd, 0);
      chk("rst_p_rs1", out_p_rs1, 0);
      tick();
      reset = 0;

      // reset state, then a plain source lookup
      @(negedge clk);
      chk("t1_out_valid", out_valid, 0);
      chk("t1_free_count", free_count, 32);
      tick();
      set_lane(0, 5, 0, 0, 0);
      set_lane(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("t1_in_ready", in_ready, 1);
      tick();
      idle();
      @(negedge clk);
      chk("t1_valid", out_valid, 1);
      chk("t1_p_rs1", o_rs1(0), 5);

      // independent pair
      do_reset();
      set_lane(0, 2, 3, 1, 1);
      set_lane(1, 5, 6, 4, 1);
      tick();
      idle();
      @(negedge clk);
      chk("t2_p_rd0", o_rd(0), 32);
      chk("t2_old0", o_old(0), 1);
      chk("t2_p_rd1", o_rd(1), 33);
      chk("t2_old1", o_old(1), 4);
      chk("t2_rs2_1", o_rs2(1), 6);
      chk("t2_free", free_count, 30);

      // intra-group dependency on x7
      do_reset();
      set_lane(0, 0, 0, 7, 1);
      set_lane(1, 7, 0, 7, 1);
      tick();
      set_lane(0, 7, 0, 0, 0);
      set_lane(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("t3_p_rd0", o_rd(0), 32);
      chk("t3_rs1_1", o_rs1(1), 32);
      chk("t3_old1", o_old(1), 32);
      chk("t3_p_rd1", o_rd(1), 33);
      tick();
      idle();
      @(negedge clk);
      chk("t3_next_rs1", o_rs1(0), 33);

      // exhaustion down to one free reg
      do_reset();
      for (int k = 0; k < 15; k++) begin
         set_lane(0, 0, 0, 2*k+1, 1);
         set_lane(1, 0, 0, 2*k+2, 1);
         tick();
      end
      set_lane(0, 0, 0, 31, 1);
      set_lane(1, 0, 0, 0, 0);
      tick();
      set_lane(0, 0, 0, 3, 1);
      set_lane(1, 0, 0, 4, 1);
      @(negedge clk);
      chk("t4_free1", free_count, 1);
      chk("t4_stall", in_ready, 0);
      tick();
      set_commit(0, 1, 32, 1);
      @(negedge clk);
      chk("t4_drained", out_valid, 0);
      chk("t4_no_bypass", in_ready, 0);
      chk("t4_free_still1", free_count, 1);
      tick();
      commit_valid = '0;
      @(negedge clk);
      chk("t4_ready_after", in_ready, 1);
      chk("t4_free2", free_count, 2);
      tick();
      idle();
      @(negedge clk);
      chk("t4_p_rd0", o_rd(0), 1);
      chk("t4_p_rd1", o_rd(1), 63);
      chk("t4_old0", o_old(0), 34);
      chk("t4_free0", free_count, 0);

      // x0 destinations and backpressure
      do_reset();
      set_lane(0, 3, 0, 0, 1);
      set_lane(1, 0, 0, 9, 0);
      tick();
      set_lane(0, 0, 0, 5, 1);
      set_lane(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("t5_x0_p_rd0", o_rd(0), 0);
      chk("t5_x0_old0", o_old(0), 0);
      chk("t5_nowe_p_rd1", o_rd(1), 0);
      chk("t5_rs1", o_rs1(0), 3);
      chk("t5_free", free_count, 32);
      tick();
      out_ready = 0;
      set_lane(0, 0, 0, 6, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t5_hold_ready", in_ready, 0);
         chk("t5_hold_valid", out_valid, 1);
         chk("t5_hold_p_rd", o_rd(0), 32);
         chk("t5_hold_free", free_count, 31);
         tick();
      end
      out_ready = 1;
      @(negedge clk);
      chk("t5_release", in_ready, 1);
      tick();
      idle();
      @(negedge clk);
      chk("t5_next_p_rd", o_rd(0), 33);

      // flush with a same-cycle commit
      do_reset();
      set_lane(0, 0, 0, 1, 1);
      set_lane(1, 0, 0, 0, 0);
      tick();
      tick();
      set_lane(0, 0, 0, 2, 1);
      set_commit(0, 1, 32, 1);
      flush = 1;
      @(negedge clk);
      chk("t6_flush_blocks", in_ready, 0);
      chk("t6_second_p_rd", o_rd(0), 33);
      tick();
      idle();
      @(negedge clk);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_free", free_count, 32);
      set_lane(0, 1, 0, 2, 1);
      set_lane(1, 0, 0, 3, 1);
      tick();
      idle();
      @(negedge clk);
      chk("t6_rat1", o_rs1(0), 32);
      chk("t6_alloc_lo", o_rd(0), 1);
      chk("t6_alloc_hi", o_rd(1), 33);
      chk("t6_old0", o_old(0), 2);

      // randomized traffic
      do_reset();
      repeat (4000) begin
         drive_random();
         tick();
      end
      idle();
      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
